// File: rtl/fft_pkg.sv
// Shared definitions for the FFT output reorder path.
//   WD     : signed width of each real/imag component
//   LOG2N  : log2 of the FFT size
//   N      : FFT size (16 bins)
//   cplx_t : one complex sample {re, im}
//   bitrev : reverse the LOG2N-bit bin index
package fft_pkg;

    localparam int WD    = 12;
    localparam int LOG2N = 4;
    localparam int N     = 1 << LOG2N;

    typedef struct packed {
        logic signed [WD-1:0] re;
        logic signed [WD-1:0] im;
    } cplx_t;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] idx);
        logic [LOG2N-1:0] r;
        r = {<<{idx}};
        return r;
    endfunction

endpackage

// File: rtl/fft_bitrev_reorder_if.sv
// Handshake bundle for the reorder buffer: bit-reversed input stream,
// natural-order output stream and the resync error pulse.
//   master : producer/consumer side (drives in_*, out_ready)
//   slave  : reorder buffer side (drives in_ready, out_*, sync_err)
interface fft_bitrev_reorder_if #(
    parameter int WD    = fft_pkg::WD,
    parameter int LOG2N = fft_pkg::LOG2N
);

    logic                 in_valid;
    logic                 in_ready;
    logic                 in_sof;
    logic signed [WD-1:0] in_re;
    logic signed [WD-1:0] in_im;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [WD-1:0] out_re;
    logic signed [WD-1:0] out_im;
    logic [LOG2N-1:0]     out_idx;
    logic                 out_last;
    logic                 sync_err;

    modport master (
        output in_valid, in_sof, in_re, in_im, out_ready,
        input  in_ready, out_valid, out_re, out_im, out_idx, out_last, sync_err
    );

    modport slave (
        input  in_valid, in_sof, in_re, in_im, out_ready,
        output in_ready, out_valid, out_re, out_im, out_idx, out_last, sync_err
    );

endinterface

// File: rtl/fft_pingpong_ram.sv
// Two-bank N-entry complex flop array: one synchronous write port and one
// combinational read port. Whole array clears on async reset.
//   clk, rst_n    : clock, async active-low reset
//   we/wbank/waddr/wdata : write strobe, bank, entry, sample
//   rbank/raddr   : read bank and entry
//   rdata         : sample at {rbank, raddr}
module fft_pingpong_ram
    import fft_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic             wbank,
    input  logic [LOG2N-1:0] waddr,
    input  cplx_t            wdata,
    input  logic             rbank,
    input  logic [LOG2N-1:0] raddr,
    output cplx_t            rdata
);

    cplx_t mem [2][N];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem <= '{default: '0};
        end else if (we) begin
            mem[wbank][waddr] <= wdata;
        end
    end

    assign rdata = mem[rbank][raddr];

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Output reorder buffer for the 16-point radix-2 FFT. Buffers each
// bit-reversed frame in a ping-pong store and re-emits it in natural order.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of fft_bitrev_reorder_if
//                in_valid/in_ready/in_sof/in_re/in_im   - input stream
//                out_valid/out_ready/out_re/out_im      - output stream
//                out_idx/out_last                       - bin index, last bin
//                sync_err                               - mid-frame in_sof pulse
module fft_bitrev_reorder #(
    parameter int WD    = fft_pkg::WD,
    parameter int LOG2N = fft_pkg::LOG2N
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fft_bitrev_reorder_if.slave   bus
);

    import fft_pkg::*;

    logic [1:0]       full;
    logic [1:0]       full_nxt;
    logic             wr_bank;
    logic             rd_bank;
    logic [LOG2N-1:0] wr_cnt;
    logic [LOG2N-1:0] rd_cnt;
    logic             sync_err_q;

    logic             in_ready;
    logic             out_valid;
    logic             accept;
    logic             xfer;
    logic             wr_done;
    logic             rd_done;
    logic [LOG2N-1:0] waddr;
    cplx_t            wdata;
    cplx_t            rdata;
    logic signed [WD-1:0] rd_re;
    logic signed [WD-1:0] rd_im;

    assign in_ready  = !full[wr_bank];
    assign out_valid = full[rd_bank];
    assign accept    = bus.in_valid & in_ready;
    assign xfer      = out_valid & bus.out_ready;

    // in_sof forces the write to slot 0 of the frame, restarting it.
    assign waddr   = bus.in_sof ? '0 : bitrev(wr_cnt);
    assign wr_done = accept & !bus.in_sof & (&wr_cnt);
    assign rd_done = xfer & (&rd_cnt);
    assign wdata   = '{re: bus.in_re, im: bus.in_im};

    // wr_done needs full[wr_bank]=0 and rd_done needs full[rd_bank]=1, so
    // they always target different banks.
    always_comb begin
        full_nxt = full;
        if (wr_done) full_nxt[wr_bank] = 1'b1;
        if (rd_done) full_nxt[rd_bank] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full       <= '0;
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b0;
            wr_cnt     <= '0;
            rd_cnt     <= '0;
            sync_err_q <= 1'b0;
        end else begin
            full       <= full_nxt;
            sync_err_q <= accept & bus.in_sof & (wr_cnt != '0);
            if (accept) begin
                if (bus.in_sof) wr_cnt <= LOG2N'(1);
                else            wr_cnt <= wr_cnt + 1'b1;
            end
            if (wr_done) wr_bank <= ~wr_bank;
            if (xfer)    rd_cnt  <= rd_cnt + 1'b1;
            if (rd_done) rd_bank <= ~rd_bank;
        end
    end

    fft_pingpong_ram u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (accept),
        .wbank (wr_bank),
        .waddr (waddr),
        .wdata (wdata),
        .rbank (rd_bank),
        .raddr (rd_cnt),
        .rdata (rdata)
    );

    assign rd_re = rdata.re;
    assign rd_im = rdata.im;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_re    = rd_re;
    assign bus.out_im    = rd_im;
    assign bus.out_idx   = rd_cnt;
    assign bus.out_last  = out_valid & (&rd_cnt);
    assign bus.sync_err  = sync_err_q;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
module tb_fft_bitrev_reorder;

    localparam int WD    = 12;
    localparam int LOG2N = 4;
    localparam int N     = 16;
    localparam int REV [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    fft_bitrev_reorder_if #(.WD(WD), .LOG2N(LOG2N)) bus ();

    fft_bitrev_reorder #(.WD(WD), .LOG2N(LOG2N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Present one sample at a negedge once in_ready is seen; returns at the
    // negedge after the accepting posedge. waits = cycles spent stalled.
    task automatic push(input int re, input int im, input logic sof, output int waits);
        waits = 0;
        while (bus.in_ready !== 1'b1 && waits < 64) begin
            bus.in_valid = 1'b0;
            @(negedge clk);
            waits++;
        end
        bus.in_valid = 1'b1;
        bus.in_sof   = sof;
        bus.in_re    = WD'(re);
        bus.in_im    = WD'(im);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_idx !== 4'd0 ||
            bus.out_last !== 1'b0 || bus.sync_err !== 1'b0 || bus.out_re !== 12'sd0 || bus.out_im !== 12'sd0)
            begin
            failures++;
            $display("FAIL reset: in_ready=%b out_valid=%b idx=%0d last=%b serr=%b re=%0d im=%0d",
                     bus.in_ready, bus.out_valid, bus.out_idx, bus.out_last, bus.sync_err, bus.out_re, bus.out_im);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_frame();
        int w;
        logic signed [WD-1:0] er, ei;
        bus.out_ready = 1'b1;
        for (int p = 0; p < N; p++) begin
            if (p == N-1) begin
                checks++;
                if (bus.out_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL single_early_valid: out_valid=%b required 0", bus.out_valid);
                end
            end
            push(p, -p, p == 0, w);
            checks++;
            if (w != 0) begin
                failures++;
                $display("FAIL single_in_ready: p=%0d stalled %0d cycles required 0", p, w);
            end
        end
        for (int n = 0; n < N; n++) begin
            er = WD'(REV[n]);
            ei = WD'(-REV[n]);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_idx !== 4'(n) || bus.out_re !== er ||
                bus.out_im !== ei || bus.out_last !== (n == N-1)) begin
                failures++;
                $display("FAIL single n=%0d: v=%b idx=%0d re=%0d im=%0d last=%b required re=%0d im=%0d",
                         n, bus.out_valid, bus.out_idx, bus.out_re, bus.out_im, bus.out_last, er, ei);
            end
            @(negedge clk);
        end
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_after: out_valid=%b required 0", bus.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b1;
        fork
            begin
                int w;
                for (int k = 0; k < 4*N; k++) begin
                    push(1000 + k, -(1000 + k), (k % N) == 0, w);
                    checks++;
                    if (w != 0) begin
                        failures++;
                        $display("FAIL stream_in_ready: k=%0d stalled %0d required 0", k, w);
                    end
                end
            end
            begin
                int t;
                logic signed [WD-1:0] er, ei;
                t = 0;
                while (bus.out_valid !== 1'b1 && t < 40) begin
                    @(negedge clk);
                    t++;
                end
                checks++;
                if (t >= 40) begin
                    failures++;
                    $display("FAIL stream_timeout: out_valid=%b required 1", bus.out_valid);
                end
                for (int k = 0; k < 4*N; k++) begin
                    er = WD'(1000 + (k / N) * N + REV[k % N]);
                    ei = WD'(-(1000 + (k / N) * N + REV[k % N]));
                    checks++;
                    if (bus.out_valid !== 1'b1 || bus.out_idx !== 4'(k % N) ||
                        bus.out_re !== er || bus.out_im !== ei) begin
                        failures++;
                        $display("FAIL stream k=%0d: v=%b idx=%0d re=%0d im=%0d required re=%0d im=%0d",
                                 k, bus.out_valid, bus.out_idx, bus.out_re, bus.out_im, er, ei);
                    end
                    @(negedge clk);
                end
            end
        join
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL stream_after: out_valid=%b required 0", bus.out_valid);
        end
    endtask

    task automatic test_backpressure();
        int w;
        logic signed [WD-1:0] er;
        bus.out_ready = 1'b0;
        for (int k = 0; k < 2*N; k++) begin
            push(100 + k, -(100 + k), (k % N) == 0, w);
            checks++;
            if (w != 0) begin
                failures++;
                $display("FAIL bp_in_ready: k=%0d stalled %0d required 0", k, w);
            end
        end
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
            failures++;
            $display("FAIL bp_full: in_ready=%b out_valid=%b required 0/1", bus.in_ready, bus.out_valid);
        end
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (bus.out_idx !== 4'd0 || bus.out_re !== 12'sd100) begin
                failures++;
                $display("FAIL bp_hold0 c=%0d: idx=%0d re=%0d required 0/100", c, bus.out_idx, bus.out_re);
            end
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        bus.out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_idx !== 4'd3 || bus.out_re !== 12'sd112) begin
                failures++;
                $display("FAIL bp_hold3 c=%0d: v=%b idx=%0d re=%0d required 1/3/112",
                         c, bus.out_valid, bus.out_idx, bus.out_re);
            end
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        for (int k = 3; k < 2*N; k++) begin
            er = WD'(100 + (k / N) * N + REV[k % N]);
            if (k == N) begin
                checks++;
                if (bus.in_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL bp_in_ready_reopen: in_ready=%b required 1", bus.in_ready);
                end
            end
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_idx !== 4'(k % N) || bus.out_re !== er) begin
                failures++;
                $display("FAIL bp_drain k=%0d: v=%b idx=%0d re=%0d required re=%0d",
                         k, bus.out_valid, bus.out_idx, bus.out_re, er);
            end
            @(negedge clk);
        end
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_after: out_valid=%b required 0", bus.out_valid);
        end
    endtask

    task automatic test_resync();
        int w;
        logic signed [WD-1:0] er, ei;
        bus.out_ready = 1'b1;
        for (int p = 0; p < 5; p++) push(200 + p, -(200 + p), p == 0, w);
        checks++;
        if (bus.sync_err !== 1'b0) begin
            failures++;
            $display("FAIL resync_pre: sync_err=%b required 0", bus.sync_err);
        end
        for (int p = 0; p < N; p++) begin
            push(300 + p, -(300 + p), p == 0, w);
            if (p == 0) begin
                checks++;
                if (bus.sync_err !== 1'b1) begin
                    failures++;
                    $display("FAIL resync_pulse: sync_err=%b required 1", bus.sync_err);
                end
            end else if (p == 1) begin
                checks++;
                if (bus.sync_err !== 1'b0) begin
                    failures++;
                    $display("FAIL resync_pulse_end: sync_err=%b required 0", bus.sync_err);
                end
            end
        end
        for (int n = 0; n < N; n++) begin
            er = WD'(300 + REV[n]);
            ei = WD'(-(300 + REV[n]));
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_idx !== 4'(n) || bus.out_re !== er || bus.out_im !== ei) begin
                failures++;
                $display("FAIL resync n=%0d: v=%b idx=%0d re=%0d im=%0d required re=%0d im=%0d",
                         n, bus.out_valid, bus.out_idx, bus.out_re, bus.out_im, er, ei);
            end
            @(negedge clk);
        end
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL resync_after: out_valid=%b required 0", bus.out_valid);
        end
    endtask

    task automatic test_async_reset();
        int w;
        logic signed [WD-1:0] er;
        bus.out_ready = 1'b1;
        for (int p = 0; p < N; p++) push(400 + p, -(400 + p), p == 0, w);
        repeat (7) @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_idx !== 4'd7 || bus.out_re !== 12'sd414) begin
            failures++;
            $display("FAIL arst_pre: v=%b idx=%0d re=%0d required 1/7/414", bus.out_valid, bus.out_idx, bus.out_re);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_idx !== 4'd0 || bus.out_last !== 1'b0) begin
            failures++;
            $display("FAIL arst_immediate: v=%b in_ready=%b idx=%0d last=%b required 0/1/0/0",
                     bus.out_valid, bus.in_ready, bus.out_idx, bus.out_last);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int p = 0; p < N; p++) push(500 + p, -(500 + p), p == 0, w);
        for (int n = 0; n < N; n++) begin
            er = WD'(500 + REV[n]);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_idx !== 4'(n) || bus.out_re !== er) begin
                failures++;
                $display("FAIL arst_fresh n=%0d: v=%b idx=%0d re=%0d required re=%0d",
                         n, bus.out_valid, bus.out_idx, bus.out_re, er);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_extremes();
        int w;
        logic signed [WD-1:0] er, ei;
        bus.out_ready = 1'b1;
        for (int p = 0; p < N; p++) begin
            if (p % 2 == 0) push(2047, -2048, p == 0, w);
            else            push(-2048, 2047, p == 0, w);
        end
        // Bin n holds arrival position REV[n]; that position is even for n<8.
        for (int n = 0; n < N; n++) begin
            er = (n < 8) ? 12'sd2047 : -12'sd2048;
            ei = (n < 8) ? -12'sd2048 : 12'sd2047;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_re !== er || bus.out_im !== ei) begin
                failures++;
                $display("FAIL extremes n=%0d: v=%b re=%0d im=%0d required re=%0d im=%0d",
                         n, bus.out_valid, bus.out_re, bus.out_im, er, ei);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_sof    = 1'b0;
        bus.in_re     = '0;
        bus.in_im     = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_backpressure();
        test_resync();
        test_async_reset();
        test_extremes();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fft_bitrev_reorder.md
Name: fft_bitrev_reorder

Overview:
- Output reorder buffer for the 16-point radix-2 delay-feedback FFT.
- The butterfly pipeline emits bins in bit-reversed order. This block buffers each frame and re-emits it in natural bin order (0..N-1) to the downstream consumer.
- Ping-pong storage of two N-entry complex frames. Sustains one sample per cycle with valid/ready handshakes on both sides.

Parameters:
- WD, 12, signed width of each real/imag component (matches butterfly output)
- LOG2N, 4, log2 of FFT size; N = 2**LOG2N = 16

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input sample present
- in_ready  out  1  block can accept an input sample
- in_sof  in  1  start-of-frame marker, qualifies the accepted sample
- in_re  in  WD  signed real part, bit-reversed arrival order
- in_im  in  WD  signed imaginary part
- out_valid  out  1  output sample present
- out_ready  in  1  downstream accepts output sample
- out_re  out  WD  signed real part, natural order
- out_im  out  WD  signed imaginary part
- out_idx  out  LOG2N  natural bin index of the current output sample
- out_last  out  1  high with bin N-1
- sync_err  out  1  one-cycle pulse: in_sof arrived mid-frame

Behaviour:
- Reset (async, rst_n=0): full[1:0]=0, wr_bank=0, rd_bank=0, wr_cnt=0, rd_cnt=0, sync_err=0, storage cleared to 0.
  - Resulting outputs: in_ready=1, out_valid=0, out_re=out_im=0, out_idx=0, out_last=0.
  - Reset mid-frame discards all buffered data.
- Storage: two banks of N complex entries, flop array.
- Write side:
  - in_ready = !full[wr_bank].
  - Accept = in_valid & in_ready.
  - On accept, write entry bitrev(wr_cnt) of bank wr_bank, then wr_cnt++.
  - When the accepted write has wr_cnt==N-1: set full[wr_bank], toggle wr_bank, wr_cnt:=0.
- Resync:
  - Accept with in_sof=1 writes address bitrev(0) and sets wr_cnt:=1, regardless of current wr_cnt.
  - If wr_cnt!=0 at that time, the partial frame is discarded (overwritten) and sync_err pulses high for one cycle.
  - in_sof=0 with wr_cnt==0 is legal; in_sof is optional framing.
- Read side:
  - out_valid = full[rd_bank].
  - out_re/out_im = entry rd_cnt of bank rd_bank, combinational read of the flop array.
  - out_idx = rd_cnt; out_last = out_valid & (rd_cnt==N-1).
  - When out_valid is low, data outputs are don't-care; the bench checks only when valid.
  - Transfer = out_valid & out_ready, then rd_cnt++.
  - Transfer at rd_cnt==N-1: clear full[rd_bank], toggle rd_bank, rd_cnt:=0.
- Latency: first output is valid the cycle after the N-th input of a frame is accepted.
  - Back-to-back frames with out_ready=1 flow continuously: in_ready never deasserts, output is gap-free.
- Simultaneous events:
  - Setting full on one bank while clearing it on the other bank in the same cycle is legal; both updates take effect.
  - The same bank can never be set and cleared in the same cycle.
- Backpressure: out_ready low stalls the read; out data and out_idx hold stable while out_valid=1 and out_ready=0.
  - When both banks are full, in_ready=0 until the reading bank drains.
- Arithmetic: none. Data passes bit-exact; no saturation or rounding.

Decomposition:
- Shared package fft_pkg:
  - localparams WD=12, LOG2N=4, N=16
  - complex sample typedef {re, im} of signed [WD-1:0]
  - function bitrev(idx, LOG2N)
- One natural sub-module: fft_pingpong_ram, a two-bank N x 2WD flop array with one write port and one combinational read port.
  - The top level holds the counters, full flags and handshake logic.

Test Plan:
- Single frame: 16 accepted inputs, in_sof on the first, arrival position p carries re=p, im=-p.
  - Output idx n carries re=bitrev(n), e.g. idx1→re=8/im=-8, idx3→re=12, idx15→re=15.
  - out_last is high only at idx15; first out_valid is 1 cycle after the 16th accept.
- Streaming: 4 back-to-back frames with out_ready=1.
  - in_ready stays 1 throughout; 64 consecutive outputs with no gaps, each frame correctly reordered.
- Backpressure: out_ready=0 while 32 inputs arrive.
  - in_ready drops to 0 after the 32nd accept. Raising out_ready drains frame A then frame B in order.
  - out_idx holds stable during the stall.
- Resync: in_sof=1 on the 6th sample of a frame.
  - sync_err pulses for exactly 1 cycle; the 5 earlier samples are discarded.
  - The next 16 samples from the in_sof sample form a correct frame.
- Async reset: assert rst_n=0 mid-drain at idx 7.
  - out_valid=0 and in_ready=1 immediately, with no clock edge needed.
  - After release, a fresh frame reorders correctly.
- Extremes: samples re=2047/-2048, im=-2048/2047 pass through bit-exact.
